// File: rtl/i2c_slave.sv
// i2c_slave: byte-level I2C responder with 7-bit address match.
// Bus lines are oversampled on clk (2-flop synchroniser + delay flop), START/STOP
// are detected on the synchronised values, write bytes are ACKed and read bytes
// are shifted out from tx_data. sda_oe = 1 pulls SDA low (open-drain pad model).
// Optional feature macro: I2C_SLAVE_GCALL_EN (ACK the general-call write address 8'h00).
module i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk,
    input  logic       asyn_rst,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic [7:0] tx_data,
    output logic       tx_req,
    output logic       rw,
    output logic       busy
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] ADDR     = 3'd1;
    localparam logic [2:0] ADDR_ACK = 3'd2;
    localparam logic [2:0] RX_BYTE  = 3'd3;
    localparam logic [2:0] RX_ACK   = 3'd4;
    localparam logic [2:0] TX_BYTE  = 3'd5;
    localparam logic [2:0] TX_ACK   = 3'd6;

    logic       scl_s1_r, scl_s2_r, scl_d_r;
    logic       sda_s1_r, sda_s2_r, sda_d_r;
    logic [2:0] state_r;
    logic [2:0] bit_cnt_r;
    logic [7:0] shift_r;
    logic       byte_done_r;

    logic scl_rise_s, scl_fall_s, scl_high_s;
    logic start_s, stop_s;
    logic addr_match_s;

    // Synchronise the pad lines; reset to the idle-high level so no false edge appears.
    always_ff @(posedge clk) begin
        if (asyn_rst) begin
            scl_s1_r <= 1'b1;
            scl_s2_r <= 1'b1;
            scl_d_r  <= 1'b1;
            sda_s1_r <= 1'b1;
            sda_s2_r <= 1'b1;
            sda_d_r  <= 1'b1;
        end else begin
            scl_s1_r <= scl_in;
            scl_s2_r <= scl_s1_r;
            scl_d_r  <= scl_s2_r;
            sda_s1_r <= sda_in;
            sda_s2_r <= sda_s1_r;
            sda_d_r  <= sda_s2_r;
        end
    end

    // Edge, START/STOP and address-match decode on the synchronised lines.
    always_comb begin
        scl_rise_s = scl_s2_r & ~scl_d_r;
        scl_fall_s = ~scl_s2_r & scl_d_r;
        scl_high_s = scl_s2_r & scl_d_r;
        start_s    = scl_high_s & ~sda_s2_r & sda_d_r;
        stop_s     = scl_high_s & sda_s2_r & ~sda_d_r;
`ifdef I2C_SLAVE_GCALL_EN
        addr_match_s = (shift_r[7:1] == SLAVE_ADDR) || (shift_r == 8'h00);
`else
        addr_match_s = (shift_r[7:1] == SLAVE_ADDR);
`endif
    end

    // Protocol FSM: START/STOP take priority over SCL-edge actions.
    always_ff @(posedge clk) begin
        if (asyn_rst) begin
            state_r     <= IDLE;
            bit_cnt_r   <= 3'd0;
            shift_r     <= 8'h00;
            byte_done_r <= 1'b0;
            sda_oe      <= 1'b0;
            rx_data     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            rw          <= 1'b0;
            busy        <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            tx_req   <= 1'b0;
            if (start_s) begin
                state_r     <= ADDR;
                bit_cnt_r   <= 3'd0;
                byte_done_r <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else if (stop_s) begin
                state_r     <= IDLE;
                bit_cnt_r   <= 3'd0;
                byte_done_r <= 1'b0;
                sda_oe      <= 1'b0;
                busy        <= 1'b0;
            end else if (scl_rise_s) begin
                case (state_r)
                    ADDR, RX_BYTE: begin
                        shift_r   <= {shift_r[6:0], sda_s2_r};
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            byte_done_r <= 1'b1;
                            if (state_r == ADDR) begin
                                rw <= sda_s2_r;
                            end else begin
                                rx_data  <= {shift_r[6:0], sda_s2_r};
                                rx_valid <= 1'b1;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        if (rw) begin
                            tx_req <= 1'b1;
                        end
                    end
                    TX_BYTE: begin
                        bit_cnt_r <= bit_cnt_r + 3'd1;
                        if (bit_cnt_r == 3'd7) begin
                            byte_done_r <= 1'b1;
                        end
                    end
                    TX_ACK: begin
                        if (!sda_s2_r) begin
                            tx_req <= 1'b1;
                        end else begin
                            state_r <= IDLE;
                            busy    <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end else if (scl_fall_s) begin
                case (state_r)
                    ADDR: begin
                        if (byte_done_r) begin
                            byte_done_r <= 1'b0;
                            if (addr_match_s) begin
                                state_r <= ADDR_ACK;
                                sda_oe  <= 1'b1;
                                busy    <= 1'b1;
                            end else begin
                                state_r <= IDLE;
                            end
                        end
                    end
                    ADDR_ACK: begin
                        bit_cnt_r <= 3'd0;
                        if (rw) begin
                            state_r <= TX_BYTE;
                            shift_r <= tx_data;
                            sda_oe  <= ~tx_data[7];
                        end else begin
                            state_r <= RX_BYTE;
                            sda_oe  <= 1'b0;
                        end
                    end
                    RX_BYTE: begin
                        if (byte_done_r) begin
                            byte_done_r <= 1'b0;
                            state_r     <= RX_ACK;
                            sda_oe      <= 1'b1;
                        end
                    end
                    RX_ACK: begin
                        state_r <= RX_BYTE;
                        sda_oe  <= 1'b0;
                    end
                    TX_BYTE: begin
                        if (byte_done_r) begin
                            byte_done_r <= 1'b0;
                            state_r     <= TX_ACK;
                            sda_oe      <= 1'b0;
                        end else begin
                            shift_r <= {shift_r[6:0], 1'b0};
                            sda_oe  <= ~shift_r[6];
                        end
                    end
                    TX_ACK: begin
                        state_r   <= TX_BYTE;
                        bit_cnt_r <= 3'd0;
                        shift_r   <= tx_data;
                        sda_oe    <= ~tx_data[7];
                    end
                    default: begin
                        state_r <= state_r;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: table-driven write/NACK vectors, hand-written
// read, mid-transfer reset and repeated-START sequences, with an rx scoreboard.
module tb_i2c_slave;

    logic       clk = 1'b0;
    logic       asyn_rst;
    logic       m_scl, m_sda;
    logic       sda_bus;
    logic [7:0] tx_data;
    logic       sda_oe, rx_valid, tx_req, rw, busy;
    logic [7:0] rx_data;

    always #5 clk = ~clk;

    assign sda_bus = m_sda & ~sda_oe;

    i2c_slave dut (
        .clk      (clk),
        .asyn_rst (asyn_rst),
        .scl_in   (m_scl),
        .sda_in   (sda_bus),
        .sda_oe   (sda_oe),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .tx_data  (tx_data),
        .tx_req   (tx_req),
        .rw       (rw),
        .busy     (busy)
    );

`ifdef I2C_SLAVE_GCALL_EN
    localparam logic GC = 1'b1;
`else
    localparam logic GC = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int rx_cnt = 0;
    int txreq_cnt = 0;
    logic oe_seen = 1'b0;
    logic prev_rxv = 1'b0;
    logic prev_txr = 1'b0;
    logic [7:0] exp_rx_q[$];
    logic [7:0] tx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard/monitor: pops expected rx bytes, feeds tx bytes on tx_req.
    always @(negedge clk) begin
        if (sda_oe === 1'b1) oe_seen = 1'b1;
        if (rx_valid === 1'b1) begin
            rx_cnt++;
            check("rx_valid_width", {31'd0, prev_rxv}, 32'd0);
            if (exp_rx_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rx_unexpected: got %02h expected none", rx_data);
            end else begin
                check("rx_data", {24'd0, rx_data}, {24'd0, exp_rx_q.pop_front()});
            end
        end
        if (tx_req === 1'b1) begin
            txreq_cnt++;
            check("tx_req_width", {31'd0, prev_txr}, 32'd0);
            if (tx_q.size() != 0) tx_data = tx_q.pop_front();
        end
        prev_rxv = rx_valid;
        prev_txr = tx_req;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        wait_clk(2);
        m_sda = b;
        wait_clk(6);
        m_scl = 1'b1;
        wait_clk(4);
        s = sda_bus;
        wait_clk(4);
        m_scl = 1'b0;
    endtask

    task automatic start_cond();
        wait_clk(2);
        m_sda = 1'b1;
        wait_clk(2);
        m_scl = 1'b1;
        wait_clk(6);
        m_sda = 1'b0;
        wait_clk(6);
        m_scl = 1'b0;
    endtask

    task automatic stop_cond();
        wait_clk(2);
        m_sda = 1'b0;
        wait_clk(6);
        m_scl = 1'b1;
        wait_clk(6);
        m_sda = 1'b1;
        wait_clk(6);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic acked);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
        clock_bit(1'b1, s);
        acked = ~s;
    endtask

    task automatic recv_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            clock_bit(1'b1, s);
            d[i] = s;
        end
        clock_bit(~mack, s);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       ack;
    } vec_t;

    vec_t vecs[6];

    // Watchdog: the run is fixed-length, so this only fires on a broken bench/DUT.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic       ack;
        logic [7:0] d;
        logic       s;
        int         rx0;
        int         tr0;

        vecs[0] = '{8'hA0, 8'h3C, 1'b1};
        vecs[1] = '{8'hA2, 8'h55, 1'b0};
        vecs[2] = '{8'h00, 8'h11, GC};
        vecs[3] = '{8'h01, 8'h22, 1'b0};
        vecs[4] = '{8'hA0, 8'h81, 1'b1};
        vecs[5] = '{8'hB0, 8'h66, 1'b0};

        asyn_rst = 1'b1;
        m_scl    = 1'b1;
        m_sda    = 1'b1;
        tx_data  = 8'h00;
        wait_clk(3);
        check("rst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_tx_req", {31'd0, tx_req}, 32'd0);
        check("rst_rw", {31'd0, rw}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        asyn_rst = 1'b0;
        wait_clk(5);

        // Table-driven write / NACK transactions.
        for (int i = 0; i < 6; i++) begin
            rx0     = rx_cnt;
            oe_seen = 1'b0;
            start_cond();
            send_byte(vecs[i].addr, ack);
            check("addr_ack", {31'd0, ack}, {31'd0, vecs[i].ack});
            if (vecs[i].ack) begin
                check("rw_write", {31'd0, rw}, 32'd0);
                check("busy_addressed", {31'd0, busy}, 32'd1);
                exp_rx_q.push_back(vecs[i].data);
                send_byte(vecs[i].data, ack);
                check("data_ack", {31'd0, ack}, 32'd1);
                check("rx_data_hold", {24'd0, rx_data}, {24'd0, vecs[i].data});
            end else begin
                check("nack_no_oe", {31'd0, oe_seen}, 32'd0);
                check("nack_busy", {31'd0, busy}, 32'd0);
            end
            stop_cond();
            check("busy_after_stop", {31'd0, busy}, 32'd0);
            check("rx_count", rx_cnt - rx0, vecs[i].ack ? 32'd1 : 32'd0);
        end

        // Reset asserted mid-RX_BYTE.
        start_cond();
        send_byte(8'hA0, ack);
        check("rst_seq_ack", {31'd0, ack}, 32'd1);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        check("rst_seq_busy_before", {31'd0, busy}, 32'd1);
        asyn_rst = 1'b1;
        wait_clk(1);
        check("midrst_sda_oe", {31'd0, sda_oe}, 32'd0);
        check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
        check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("midrst_tx_req", {31'd0, tx_req}, 32'd0);
        check("midrst_rw", {31'd0, rw}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        wait_clk(1);
        asyn_rst = 1'b0;
        oe_seen  = 1'b0;
        rx0      = rx_cnt;
        for (int i = 0; i < 5; i++) clock_bit(1'b0, s);
        stop_cond();
        check("post_rst_ignored_oe", {31'd0, oe_seen}, 32'd0);
        check("post_rst_no_rx", rx_cnt - rx0, 32'd0);

        // Read: two bytes, master ACK then NACK.
        tx_q.push_back(8'h96);
        tx_q.push_back(8'h5A);
        tr0 = txreq_cnt;
        start_cond();
        send_byte(8'hA1, ack);
        check("read_addr_ack", {31'd0, ack}, 32'd1);
        check("read_rw", {31'd0, rw}, 32'd1);
        check("read_busy", {31'd0, busy}, 32'd1);
        recv_byte(1'b1, d);
        check("read_byte0", {24'd0, d}, 32'h96);
        recv_byte(1'b0, d);
        check("read_byte1", {24'd0, d}, 32'h5A);
        check("read_idle_after_nack", {31'd0, busy}, 32'd0);
        check("read_tx_req_count", txreq_cnt - tr0, 32'd2);
        stop_cond();

        // Repeated START mid-byte aborts the write, then a read proceeds.
        rx0 = rx_cnt;
        start_cond();
        send_byte(8'hA0, ack);
        check("rs_write_ack", {31'd0, ack}, 32'd1);
        clock_bit(1'b1, s);
        clock_bit(1'b1, s);
        clock_bit(1'b0, s);
        clock_bit(1'b0, s);
        tx_q.push_back(8'h77);
        start_cond();
        send_byte(8'hA1, ack);
        check("rs_read_ack", {31'd0, ack}, 32'd1);
        check("rs_rw", {31'd0, rw}, 32'd1);
        recv_byte(1'b0, d);
        check("rs_read_byte", {24'd0, d}, 32'h77);
        stop_cond();
        check("rs_no_rx_valid", rx_cnt - rx0, 32'd0);

        check("scoreboard_drained", exp_rx_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
